// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with flip-flop
// valid/tag/data arrays, 1-cycle registered hit latency, whole-line refill
// over a req/valid memory handshake, and single-cycle global flush.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_assoc #(
    parameter int N_WAYS             = 2,
    parameter int N_SETS             = 8,
    parameter int N_CACHELINE_LENGTH = 4,
    parameter int BITSIZE            = 32,
    parameter int OFFSET_BITS        = $clog2(N_CACHELINE_LENGTH),
    parameter int INDEX_BITS         = $clog2(N_SETS),
    parameter int TAGSIZE            = 30 - INDEX_BITS - OFFSET_BITS
) (
    input  logic                                  clk,
    input  logic                                  resetn_i,
    input  logic                                  req_i,
    input  logic [31:0]                           addr_i,
    input  logic                                  flush_i,
    output logic                                  ready_o,
    output logic                                  rd_valid_o,
    output logic [BITSIZE-1:0]                    instruction_o,
    output logic                                  mem_req_o,
    output logic [31:0]                           mem_addr_o,
    input  logic                                  mem_valid_i,
    input  logic [BITSIZE*N_CACHELINE_LENGTH-1:0] mem_data_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                           hit_cnt_o,
    output logic [31:0]                           miss_cnt_o
`endif
);

    // A 1-way cache still needs a 1-bit way pointer to keep vectors legal.
    localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

    state_t state_q, state_d;

    logic [N_WAYS-1:0]  valid_q  [N_SETS];
    logic [TAGSIZE-1:0] tag_q    [N_SETS][N_WAYS];
    logic [BITSIZE-1:0] data_q   [N_SETS][N_WAYS][N_CACHELINE_LENGTH];
    logic [WAY_W-1:0]   rr_ptr_q [N_SETS];

    logic [OFFSET_BITS-1:0] req_off_q;
    logic [INDEX_BITS-1:0]  req_idx_q;
    logic [TAGSIZE-1:0]     req_tag_q;
    logic                   flush_pend_q;

    logic [OFFSET_BITS-1:0] addr_off;
    logic [INDEX_BITS-1:0]  addr_idx;
    logic [TAGSIZE-1:0]     addr_tag;
    logic                   unused_addr_lsb;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             accept;
    logic             refill_done;
    logic             clear_valid;

    assign addr_off        = addr_i[OFFSET_BITS+1:2];
    assign addr_idx        = addr_i[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
    assign addr_tag        = addr_i[31:32-TAGSIZE];
    assign unused_addr_lsb = ^addr_i[1:0];

    assign accept      = req_i && ready_o;
    assign refill_done = (state_q == REFILL) && mem_valid_i;
    assign clear_valid = ((state_q == IDLE) && flush_i) || (state_q == FLUSH);

    // Tag lookup on the incoming address; descending scan lets the lowest way win.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_idx][w] && (tag_q[addr_idx][w] == addr_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way of the refill set, else the round-robin pointer.
    always_comb begin
        victim = rr_ptr_q[req_idx_q];
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx_q][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next-state logic; a flush seen during refill diverts to FLUSH afterwards.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !hit) state_d = REFILL;
            REFILL:  if (mem_valid_i) state_d = (flush_pend_q || flush_i) ? FLUSH : IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: requests are only taken in IDLE and never alongside a flush.
    always_comb begin
        ready_o = (state_q == IDLE) && !flush_i;
    end

    // Response, refill request and pending-flush registers.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_valid_o    <= 1'b0;
            instruction_o <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            flush_pend_q  <= 1'b0;
        end else begin
            rd_valid_o <= (accept && hit) || refill_done;
            if (accept && hit) begin
                instruction_o <= data_q[addr_idx][hit_way][addr_off];
            end else if (refill_done) begin
                instruction_o <= mem_data_i[int'(req_off_q)*BITSIZE +: BITSIZE];
            end
            if (accept && !hit) begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= {addr_i[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
            end else if (refill_done) begin
                mem_req_o  <= 1'b0;
            end
            if (refill_done)                          flush_pend_q <= 1'b0;
            else if ((state_q == REFILL) && flush_i)  flush_pend_q <= 1'b1;
        end
    end

    // Valid bits and round-robin pointers; the pointer moves only when it was the victim.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s]  <= '0;
                rr_ptr_q[s] <= '0;
            end
        end else if (clear_valid) begin
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (refill_done) begin
            valid_q[req_idx_q][victim] <= 1'b1;
            if (victim == rr_ptr_q[req_idx_q]) begin
                rr_ptr_q[req_idx_q] <= (rr_ptr_q[req_idx_q] == WAY_W'(N_WAYS - 1)) ?
                                       '0 : rr_ptr_q[req_idx_q] + 1'b1;
            end
        end
    end

    // Miss address fields and tag/data arrays; these hold no reset value.
    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            req_off_q <= addr_off;
            req_idx_q <= addr_idx;
            req_tag_q <= addr_tag;
        end
        if (refill_done) begin
            tag_q[req_idx_q][victim] <= req_tag_q;
            for (int k = 0; k < N_CACHELINE_LENGTH; k++) begin
                data_q[req_idx_q][victim][k] <= mem_data_i[k*BITSIZE +: BITSIZE];
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Accepted hit/miss counters; wrap naturally and ignore flush.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (accept) begin
            if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else     miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc (default 2-way, 8 sets,
// 4-word lines). Inputs change on the falling edge; outputs are sampled there.
module tb_icache_assoc;

    logic         clk;
    logic         resetn_i;
    logic         req_i;
    logic [31:0]  addr_i;
    logic         flush_i;
    logic         ready_o;
    logic         rd_valid_o;
    logic [31:0]  instruction_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_valid_i;
    logic [127:0] mem_data_i;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int checks;
    int failures;

    localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    icache_assoc dut (
        .clk           (clk),
        .resetn_i      (resetn_i),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .flush_i       (flush_i),
        .ready_o       (ready_o),
        .rd_valid_o    (rd_valid_o),
        .instruction_o (instruction_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_valid_i   (mem_valid_i),
        .mem_data_i    (mem_data_i)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Miss on addr, hold the refill for extra_cyc cycles, then supply line.
    task automatic fetch_miss(input string tag, input logic [31:0] addr,
                              input logic [127:0] line, input logic [31:0] exp,
                              input int extra_cyc);
        @(negedge clk);
        req_i  = 1'b1;
        addr_i = addr;
        #1 check({tag, "_ready"}, 32'(ready_o), 32'd1);
        @(negedge clk);
        req_i = 1'b0;
        check({tag, "_memreq"}, 32'(mem_req_o), 32'd1);
        check({tag, "_memaddr"}, mem_addr_o, addr & 32'hFFFF_FFF0);
        check({tag, "_norsp"}, 32'(rd_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(ready_o), 32'd0);
        for (int i = 0; i < extra_cyc; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, 32'(mem_req_o), 32'd1);
        end
        mem_valid_i = 1'b1;
        mem_data_i  = line;
        @(negedge clk);
        mem_valid_i = 1'b0;
        check({tag, "_rsp"}, 32'(rd_valid_o), 32'd1);
        check({tag, "_insn"}, instruction_o, exp);
        check({tag, "_memreq_off"}, 32'(mem_req_o), 32'd0);
    endtask

    task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        req_i  = 1'b1;
        addr_i = addr;
        @(negedge clk);
        req_i = 1'b0;
        check({tag, "_rsp"}, 32'(rd_valid_o), 32'd1);
        check({tag, "_insn"}, instruction_o, exp);
        check({tag, "_nomem"}, 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        resetn_i    = 1'b0;
        req_i       = 1'b0;
        addr_i      = '0;
        flush_i     = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdvalid", 32'(rd_valid_o), 32'd0);
        check("rst_insn", instruction_o, 32'd0);
        check("rst_memreq", 32'(mem_req_o), 32'd0);
        check("rst_memaddr", mem_addr_o, 32'd0);
        resetn_i = 1'b1;
        #1 check("rst_ready", 32'(ready_o), 32'd1);

        // Cold miss: word 1 of line 0x100
        fetch_miss("cold", 32'h0000_0104, LINE_A, 32'h22, 0);

        // Back-to-back hits, one per cycle
        @(negedge clk);
        req_i  = 1'b1;
        addr_i = 32'h100;
        @(negedge clk);
        check("b2b0_rsp", 32'(rd_valid_o), 32'd1);
        check("b2b0_insn", instruction_o, 32'h11);
        addr_i = 32'h108;
        @(negedge clk);
        check("b2b1_rsp", 32'(rd_valid_o), 32'd1);
        check("b2b1_insn", instruction_o, 32'h33);
        addr_i = 32'h10C;
        @(negedge clk);
        req_i = 1'b0;
        check("b2b2_rsp", 32'(rd_valid_o), 32'd1);
        check("b2b2_insn", instruction_o, 32'h44);
        check("b2b_nomem", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        check("b2b_idle", 32'(rd_valid_o), 32'd0);

        // Two lines in set 0 coexist
        fetch_miss("fill180", 32'h180, LINE_B, 32'hB0, 1);
        fetch_hit("hit100", 32'h104, 32'h22);
        fetch_hit("hit180", 32'h18C, 32'hB3);

        // 0x200 evicts way 0 (0x100); 0x180 survives; 0x100 misses again
        fetch_miss("fill200", 32'h208, LINE_C, 32'hC2, 0);
        fetch_hit("keep180", 32'h184, 32'hB1);
        fetch_miss("evict100", 32'h100, LINE_A, 32'h11, 0);
        fetch_hit("hit200", 32'h20C, 32'hC3);

        // Flush together with a request: request dropped, line gone
        @(negedge clk);
        req_i   = 1'b1;
        addr_i  = 32'h100;
        flush_i = 1'b1;
        #1 check("flush_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        req_i   = 1'b0;
        flush_i = 1'b0;
        check("flush_norsp", 32'(rd_valid_o), 32'd0);
        check("flush_nomem", 32'(mem_req_o), 32'd0);
        fetch_miss("postflush", 32'h100, LINE_A, 32'h11, 0);

        // Flush during refill: response still delivered, then one FLUSH cycle
        @(negedge clk);
        req_i  = 1'b1;
        addr_i = 32'h180;
        @(negedge clk);
        req_i = 1'b0;
        check("fdr_memreq", 32'(mem_req_o), 32'd1);
        flush_i = 1'b1;
        #1 check("fdr_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        check("fdr_hold1", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        check("fdr_hold2", 32'(mem_addr_o), 32'h180);
        check("fdr_norsp", 32'(rd_valid_o), 32'd0);
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_data_i  = LINE_B;
        @(negedge clk);
        mem_valid_i = 1'b0;
        check("fdr_rsp", 32'(rd_valid_o), 32'd1);
        check("fdr_insn", instruction_o, 32'hB0);
        check("fdr_flushcyc", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("fdr_idle", 32'(ready_o), 32'd1);
        check("fdr_single", 32'(rd_valid_o), 32'd0);
        fetch_miss("fdr_remiss", 32'h180, LINE_B, 32'hB0, 0);

        // Reset mid-refill: outputs drop at once; a late mem_valid_i is ignored
        @(negedge clk);
        req_i  = 1'b1;
        addr_i = 32'h300;
        @(negedge clk);
        req_i = 1'b0;
        check("rmr_memreq", 32'(mem_req_o), 32'd1);
        resetn_i = 1'b0;
        #1;
        check("rmr_memreq_off", 32'(mem_req_o), 32'd0);
        check("rmr_rdvalid_off", 32'(rd_valid_o), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check("rmr_hitcnt", hit_cnt_o, 32'd0);
        check("rmr_misscnt", miss_cnt_o, 32'd0);
`endif
        @(negedge clk);
        resetn_i = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_data_i  = LINE_D;
        @(negedge clk);
        mem_valid_i = 1'b0;
        check("rmr_late_norsp", 32'(rd_valid_o), 32'd0);
        check("rmr_late_nomem", 32'(mem_req_o), 32'd0);
        fetch_miss("rmr_cold", 32'h180, LINE_B, 32'hB0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache between the IF stage and the instruction memory port.
- Holds valid, tag and data arrays in flip-flops.
- Serves hits with 1-cycle registered latency.
- Refills whole lines on a miss through a req/valid memory handshake.
- Supports a single-cycle global flush for fence.i.

Parameters:
- N_WAYS, 2, ways per set, power of two, >=1 (1 = direct-mapped).
- N_SETS, 8, sets, power of two, >=2.
- N_CACHELINE_LENGTH, 4, 32-bit words per line, power of two, >=2.
- BITSIZE, 32, word width; fixed at 32 for instruction fetch.
- OFFSET_BITS, $clog2(N_CACHELINE_LENGTH), word-offset field width (derived).
- INDEX_BITS, $clog2(N_SETS), set-index field width (derived).
- TAGSIZE, 30 - INDEX_BITS - OFFSET_BITS, tag width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- req_i  in  1  fetch request; accepted when req_i && ready_o.
- addr_i  in  32  byte address; bits [1:0] ignored.
- flush_i  in  1  invalidate all lines.
- ready_o  out  1  cache can accept a request this cycle.
- rd_valid_o  out  1  instruction_o valid; 1-cycle pulse per accepted request.
- instruction_o  out  32  fetched instruction.
- mem_req_o  out  1  line refill request; held until mem_valid_i.
- mem_addr_o  out  32  line-aligned refill address.
- mem_valid_i  in  1  refill data present; single beat.
- mem_data_i  in  BITSIZE*N_CACHELINE_LENGTH  full line; word 0 in the LSBs.

Behaviour:
- Address split:
  - offset = addr[OFFSET_BITS+1:2]
  - index = next INDEX_BITS bits
  - tag = addr[31:32-TAGSIZE]
- Reset values: all valid bits 0, round-robin pointers 0, state IDLE. Outputs: rd_valid_o=0, instruction_o=0, mem_req_o=0, mem_addr_o=0. Data and tag arrays are not reset.
- ready_o is combinational: ready_o = (state==IDLE) && !flush_i.
- FSM states: IDLE, REFILL, FLUSH.
- IDLE:
  - flush_i=1: clear all valid bits at the edge. Stay in IDLE. No request is accepted that cycle.
  - Accepted request, hit (any way with valid && tag match): next cycle rd_valid_o=1 and instruction_o = selected word. Stay in IDLE, so back-to-back hits run at 1 per cycle.
  - Accepted request, miss: latch tag/index/offset. Next cycle: state REFILL, mem_req_o=1, mem_addr_o = {addr[31:OFFSET_BITS+2], zeros}.
- REFILL:
  - ready_o=0. mem_req_o and mem_addr_o stay stable until mem_valid_i.
  - On mem_valid_i: write the line and tag into victim way rr_ptr[index] and set its valid bit. Increment rr_ptr[index] modulo N_WAYS.
  - Next cycle: rd_valid_o=1, instruction_o = requested word taken from mem_data_i (registered), mem_req_o=0.
  - Next state is IDLE, or FLUSH if a flush is pending.
- Flush during REFILL: latched as pending. The refill completes and its response is still delivered, then the FSM enters FLUSH.
- FLUSH: one cycle, clears all valid bits, ready_o=0, then IDLE.
- Victim selection: an invalid way is preferred, lowest index first; otherwise rr_ptr. rr_ptr advances only when rr_ptr itself was the victim.
- Multiple matching ways cannot occur by construction. If they do, the lowest way wins.
- mem_valid_i outside REFILL is ignored.
- Reset mid-refill: immediate return to IDLE, mem_req_o=0, all lines invalid. A late mem_valid_i is ignored.
- rd_valid_o is never asserted without a prior accepted request. Exactly one response per accepted request, in order.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments on each accepted hit; miss_cnt_o increments on each accepted miss.
  - Both counters wrap at 2^32, reset to 0 on resetn_i and are unaffected by flush_i.
- Not defined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, req addr 0x0000_0104. Required: mem_req_o=1, mem_addr_o=0x0000_0100. Drive mem_valid_i with line {0x44,0x33,0x22,0x11}. Required: next cycle rd_valid_o=1, instruction_o=0x22.
- Back-to-back hits: reqs 0x100, 0x108, 0x10C on consecutive cycles after the line fill. Required: rd_valid_o high 3 consecutive cycles with 0x11, 0x33, 0x44, and no mem_req_o.
- Associativity and round-robin:
  - Fill 0x100 and 0x180 (same index 0), both then hit.
  - Then 0x200 evicts way 0 (0x100). Re-request 0x100: miss.
  - 0x180 still hits.
- Flush: after fills, pulse flush_i together with req_i. Required: ready_o=0 that cycle; the following request to 0x100 misses.
- Flush during refill: flush_i pulsed while mem_req_o is high, mem_valid_i 3 cycles later. Required: response delivered, then one FLUSH cycle with ready_o=0, then the same address misses.
- Reset mid-refill: assert resetn_i=0 while mem_req_o=1. Required: mem_req_o=0 and rd_valid_o=0 immediately. A later mem_valid_i produces no response. With ICACHE_PERF_CNT_EN defined, the counters read 0.
